// File: rtl/lift_pkg.sv
// Shared types and helpers for the N-floor lift controller.
package lift_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MOVE_UP = 3'd1,
    MOVE_DN = 3'd2,
    DOOR    = 3'd3,
    HALT    = 3'd4
  } state_t;

  typedef enum logic {
    UP = 1'b0,
    DN = 1'b1
  } dir_t;

  // Width of a counter that must hold values 0 .. x-1 (never less than 1 bit).
  function automatic int cnt_w(input int x);
    return (x > 1) ? $clog2(x) : 1;
  endfunction

endpackage

// File: rtl/lift_req_latch.sv
// Floor request register: latches CALL pulses, absorbs/clears the served floor,
// and reduces the registered requests relative to the cabin floor.
module lift_req_latch
  import lift_pkg::*;
#(
  parameter int N_FLOORS = 4,
  parameter int FLOOR_W  = $clog2(N_FLOORS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] call,
  input  logic                clr_en,
  input  logic [FLOOR_W-1:0]  clr_floor,
  input  logic [FLOOR_W-1:0]  cur_floor,
  output logic [N_FLOORS-1:0] pending,
  output logic                above,
  output logic                below,
  output logic                here
);

  logic [N_FLOORS-1:0] pending_q;
  logic [N_FLOORS-1:0] pending_d;

  // Next request vector: OR in new calls, knock out the floor being served.
  always_comb begin
    pending_d = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      pending_d[i] = (pending_q[i] | call[i]) &
                     ~(clr_en & (clr_floor == FLOOR_W'(i)));
    end
  end

  // Request register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Direction terms are taken from the registered requests only.
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    here  = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      above = above | (pending_q[i] & (FLOOR_W'(i) > cur_floor));
      below = below | (pending_q[i] & (FLOOR_W'(i) < cur_floor));
      here  = here  | (pending_q[i] & (FLOOR_W'(i) == cur_floor));
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/lift_controller_nfloor.sv
// N-floor SCAN lift controller: FSM, travel/door timers, emergency hold
// with resume, and registered status outputs.
module lift_controller_nfloor
  import lift_pkg::*;
#(
  parameter int N_FLOORS   = 4,
  parameter int FLOOR_W    = $clog2(N_FLOORS),
  parameter int TRAVEL_CYC = 4,
  parameter int DOOR_CYC   = 3
) (
  input  logic                CLK,
  input  logic                RES,
  input  logic [N_FLOORS-1:0] CALL,
  input  logic                EMERG,
  output logic [FLOOR_W-1:0]  FLOOR,
  output logic                MOVING_UP,
  output logic                MOVING_DN,
  output logic                DOOR_OPEN,
  output logic                ARRIVED,
  output logic [N_FLOORS-1:0] PENDING
);

  localparam int TW = cnt_w(TRAVEL_CYC);
  localparam int DW = cnt_w(DOOR_CYC);
  localparam logic [TW-1:0]      TRAVEL_LAST = TW'(TRAVEL_CYC - 1);
  localparam logic [DW-1:0]      DOOR_LAST   = DW'(DOOR_CYC - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(N_FLOORS - 1);

  state_t               state_q, state_d;
  state_t               saved_q, saved_d;
  dir_t                 dir_q, dir_d;
  logic [FLOOR_W-1:0]   floor_q, floor_d;
  logic [TW-1:0]        travel_q, travel_d;
  logic [DW-1:0]        door_q, door_d;
  logic                 moving_up_q, moving_up_d;
  logic                 moving_dn_q, moving_dn_d;
  logic                 door_open_q, door_open_d;
  logic                 arrived_q, arrived_d;

  logic [N_FLOORS-1:0]  pending_s;
  logic                 above_s, below_s, here_s;
  logic                 clr_en_s;

  // A call to the door floor is absorbed on the entry edge and for the whole stop.
  assign clr_en_s = (state_d == DOOR) || (state_q == DOOR);

  lift_req_latch #(
    .N_FLOORS (N_FLOORS),
    .FLOOR_W  (FLOOR_W)
  ) u_req (
    .clk       (CLK),
    .rst       (RES),
    .call      (CALL),
    .clr_en    (clr_en_s),
    .clr_floor (floor_d),
    .cur_floor (floor_q),
    .pending   (pending_s),
    .above     (above_s),
    .below     (below_s),
    .here      (here_s)
  );

  // Next-state, timer and floor logic.
  always_comb begin
    state_d   = state_q;
    saved_d   = saved_q;
    dir_d     = dir_q;
    floor_d   = floor_q;
    travel_d  = travel_q;
    door_d    = door_q;
    arrived_d = 1'b0;
    if (EMERG) begin
      if (state_q != HALT) begin
        saved_d = state_q;
        state_d = HALT;
      end else begin
        state_d = HALT;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (here_s) begin
            state_d = DOOR;
            door_d  = '0;
          end else if (above_s && ((dir_q == UP) || !below_s)) begin
            state_d  = MOVE_UP;
            dir_d    = UP;
            travel_d = '0;
          end else if (below_s) begin
            state_d  = MOVE_DN;
            dir_d    = DN;
            travel_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
        MOVE_UP, MOVE_DN: begin
          // Defensive: never drive the cabin past either end of the shaft.
          if (((state_q == MOVE_UP) && (floor_q == TOP_FLOOR)) ||
              ((state_q == MOVE_DN) && (floor_q == '0))) begin
            state_d  = IDLE;
            travel_d = '0;
          end else if (travel_q == TRAVEL_LAST) begin
            travel_d  = '0;
            arrived_d = 1'b1;
            if (state_q == MOVE_UP) begin
              floor_d = floor_q + FLOOR_W'(1);
            end else begin
              floor_d = floor_q - FLOOR_W'(1);
            end
            if (pending_s[floor_d]) begin
              state_d = DOOR;
              door_d  = '0;
            end else begin
              state_d = state_q;
            end
          end else begin
            travel_d = travel_q + TW'(1);
          end
        end
        DOOR: begin
          if (door_q == DOOR_LAST) begin
            door_d = '0;
            if ((dir_q == UP) ? above_s : below_s) begin
              state_d  = (dir_q == UP) ? MOVE_UP : MOVE_DN;
              travel_d = '0;
            end else if ((dir_q == UP) ? below_s : above_s) begin
              state_d  = (dir_q == UP) ? MOVE_DN : MOVE_UP;
              dir_d    = (dir_q == UP) ? DN : UP;
              travel_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            door_d = door_q + DW'(1);
          end
        end
        HALT: begin
          state_d = saved_q;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Output flags follow the next state; the door flag is held through a halt.
  always_comb begin
    moving_up_d = (state_d == MOVE_UP);
    moving_dn_d = (state_d == MOVE_DN);
    door_open_d = (state_d == DOOR) || ((state_d == HALT) && door_open_q);
  end

  // State, timers and registered outputs.
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_q     <= IDLE;
      saved_q     <= IDLE;
      dir_q       <= UP;
      floor_q     <= '0;
      travel_q    <= '0;
      door_q      <= '0;
      moving_up_q <= 1'b0;
      moving_dn_q <= 1'b0;
      door_open_q <= 1'b0;
      arrived_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      saved_q     <= saved_d;
      dir_q       <= dir_d;
      floor_q     <= floor_d;
      travel_q    <= travel_d;
      door_q      <= door_d;
      moving_up_q <= moving_up_d;
      moving_dn_q <= moving_dn_d;
      door_open_q <= door_open_d;
      arrived_q   <= arrived_d;
    end
  end

  assign FLOOR     = floor_q;
  assign MOVING_UP = moving_up_q;
  assign MOVING_DN = moving_dn_q;
  assign DOOR_OPEN = door_open_q;
  assign ARRIVED   = arrived_q;
  assign PENDING   = pending_s;

endmodule
